nfc_request_arbiter: RTL
========================

// Module: nfc_request_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one NAND flash memory controller among NUM_REQ hosts.
//  Latches the winner's command/address and pulses nfc_start, then waits for nfc_done.
//  Returns a per-requester ack plus error status. Sits between host ports and the controller's
//  nfc_cmd/RWA/nfc_start/nfc_done/command_error pins.
// PARAMETERS
//  NUM_REQ         4     number of requesters (>=2); pointer width $clog2(NUM_REQ)
//  AddressWidth    16    width of RWA / per-requester address
//  CommandWidth    3     width of nfc_cmd / per-requester command
//  TIMEOUT_CYCLES  1024  WAIT-state cycle limit (used only with NFC_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1                       single clock, all state on posedge
//  Reset          in   1                       asynchronous, active-high reset
//  req            in   NUM_REQ                 per-requester request level
//  req_cmd        in   NUM_REQ*CommandWidth    flattened commands; slot i = [i*CW +: CW]
//  req_addr       in   NUM_REQ*AddressWidth    flattened addresses; slot i = [i*AW +: AW]
//  gnt            out  NUM_REQ                 one-hot grant, held from START through RESP
//  ack            out  NUM_REQ                 one-cycle completion pulse to granted requester
//  err            out  NUM_REQ                 error flag, valid only in the cycle ack is high
//  nfc_cmd        out  CommandWidth            command to memory controller
//  RWA            out  AddressWidth            read/write address to memory controller
//  nfc_start      out  1                       one-cycle start pulse
//  nfc_done       in   1                       controller completion
//  command_error  in   1                       controller error, sampled with nfc_done
//  busy           out  1                       high in any state other than IDLE
//  timeout        out  1                       one-cycle watchdog pulse; constant 0 without macro
// BEHAVIOUR
//  Reset values (async, immediate):
//   - gnt=0, ack=0, err=0, nfc_start=0, nfc_cmd=0, RWA=0, busy=0, timeout=0
//   - rr_ptr=0, state=IDLE
//  Reset mid-operation abandons the op; no ack is issued.
//  FSM IDLE -> START -> WAIT -> RESP -> IDLE:
//   - IDLE: if |req, winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     Register gnt(onehot winner), nfc_cmd/RWA from the winner's slot; -> START. Else stay.
//   - START: nfc_start=1 for exactly this cycle; -> WAIT.
//   - WAIT: nfc_cmd/RWA/gnt held stable. On nfc_done=1, capture err_q=command_error; -> RESP.
//   - RESP: ack[winner]=1 and err[winner]=err_q for one cycle; rr_ptr=(winner+1) mod NUM_REQ;
//     gnt cleared on exit; -> IDLE.
//  Latency:
//   - req sampled high in IDLE at edge T -> nfc_start high in cycle T+1.
//   - nfc_done at edge D -> ack in cycle D+1.
//   - Minimum 4 cycles per op (IDLE, START, WAIT, RESP).
//  Handshake rules:
//   - Requester holds req, req_cmd and req_addr until ack. Slot data is sampled only in IDLE.
//   - Later changes to the slot are ignored.
//   - req dropped after grant: the op still completes and ack is still pulsed.
//   - req still high after ack: that requester competes normally; it is now lowest priority.
//  Boundary conditions:
//   - nfc_done outside WAIT (including the START cycle) is ignored.
//   - command_error is ignored unless nfc_done=1.
//   - All req high: grants rotate 0,1,2,3,0... Single req: served back-to-back with
//     one IDLE cycle between ops.
//   - rr_ptr wraps NUM_REQ-1 -> 0. NUM_REQ not a power of two: ptr never exceeds NUM_REQ-1.
//   - ack/err: at most one bit set; all-zero outside RESP.
// CONFIGURATION
//  Macro NFC_ARB_TIMEOUT_EN.
//  Defined:
//   - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYCLES without nfc_done, timeout=1 for one cycle and the FSM moves
//     to RESP with err_q=1.
//   - nfc_done in the same cycle as expiry takes precedence (normal completion, no timeout).
//  Undefined: no counter; WAIT holds indefinitely; timeout tied 0.
// TESTING
//  1. Reset asserted mid-WAIT -> all outputs 0 the same cycle, state IDLE, no ack after release.
//  2. req=4'b0100, slot2 cmd=3'b010, addr=16'h1A2B -> gnt=0100; nfc_cmd=010, RWA=1A2B;
//     nfc_start pulse next cycle; done 5 cycles later -> ack=0100, err=0.
//  3. req=4'b1111 held; nfc_done 3 cycles after each start -> grant order 0,1,2,3,0;
//     no gaps beyond IDLE.
//  4. req=4'b0010, command_error=1 with nfc_done -> ack=0010, err=0010;
//     command_error=1 without nfc_done -> ignored.
//  5. nfc_done pulsed while IDLE and while in START -> no state change, no ack.
//  6. NFC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no nfc_done -> timeout pulse after 8 WAIT cycles,
//     then ack+err for the requester; without macro, busy stays 1.

Source files
------------

// File: rtl/nfc_request_arbiter.sv
// Round-robin arbiter/sequencer sharing one NAND flash controller among NUM_REQ hosts.
// Optional WAIT-state watchdog enabled by defining NFC_ARB_TIMEOUT_EN.
module nfc_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AddressWidth   = 16,
  parameter int CommandWidth   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*CommandWidth-1:0]  req_cmd,
  input  logic [NUM_REQ*AddressWidth-1:0]  req_addr,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               ack,
  output logic [NUM_REQ-1:0]               err,
  output logic [CommandWidth-1:0]          nfc_cmd,
  output logic [AddressWidth-1:0]          RWA,
  output logic                             nfc_start,
  input  logic                             nfc_done,
  input  logic                             command_error,
  output logic                             busy,
  output logic                             timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t                    state_reg, state_next;
  logic [NUM_REQ-1:0]        gnt_reg;
  logic [CommandWidth-1:0]   cmd_reg;
  logic [AddressWidth-1:0]   addr_reg;
  logic [PW-1:0]             win_reg;
  logic [PW-1:0]             rr_ptr_reg;
  logic                      err_q_reg;

  logic [CommandWidth-1:0]   cmd_slot  [NUM_REQ];
  logic [AddressWidth-1:0]   addr_slot [NUM_REQ];
  logic                      win_found;
  logic [PW-1:0]             win_idx;
  logic [PW:0]               cand;
  logic                      to_expire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign cmd_slot[gi]  = req_cmd[gi*CommandWidth +: CommandWidth];
      assign addr_slot[gi] = req_addr[gi*AddressWidth +: AddressWidth];
    end
  endgenerate

  // Scan from the far end back toward rr_ptr so the last hit is the nearest requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ))
        cand = cand - (PW+1)'(NUM_REQ);
      if (req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

`ifdef NFC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_reg;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      to_cnt_reg <= '0;
    else if (state_reg == START)
      to_cnt_reg <= '0;
    else if (state_reg == WAIT)
      to_cnt_reg <= to_cnt_reg + TW'(1);
  end

  assign to_expire = (state_reg == WAIT) && (to_cnt_reg == TW'(TIMEOUT_CYCLES));
  assign timeout   = to_expire && !nfc_done;
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    nfc_start  = 1'b0;
    ack        = '0;
    err        = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:  if (win_found) state_next = START;
      START: begin
        nfc_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (nfc_done || to_expire) state_next = RESP;
      RESP: begin
        ack        = gnt_reg;
        err        = err_q_reg ? gnt_reg : '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      gnt_reg    <= '0;
      cmd_reg    <= '0;
      addr_reg   <= '0;
      win_reg    <= '0;
      rr_ptr_reg <= '0;
      err_q_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (win_found) begin
          gnt_reg   <= NUM_REQ'(1) << win_idx;
          cmd_reg   <= cmd_slot[win_idx];
          addr_reg  <= addr_slot[win_idx];
          win_reg   <= win_idx;
          err_q_reg <= 1'b0;
        end
        WAIT: begin
          if (nfc_done)
            err_q_reg <= command_error;
          else if (to_expire)
            err_q_reg <= 1'b1;
        end
        RESP: begin
          gnt_reg    <= '0;
          rr_ptr_reg <= (win_reg == PW'(NUM_REQ - 1)) ? '0 : win_reg + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign nfc_cmd = cmd_reg;
  assign RWA     = addr_reg;

endmodule
